// File: rtl/aggregator.sv
// aggregator -- packs a stream of narrow words into wide multi-lane words.
//
// Words are dequeued one per cycle from a narrow upstream FIFO. Each word fills
// the next free lane of an assembly register, starting at lane 0. When the last
// lane is filled, the assembled word moves into a single-entry output register,
// which is offered to a wide downstream FIFO. A flush request sends a partially
// filled word early, together with a lane-valid mask.
//
// Ports:
//   clk              clock
//   rst              synchronous active-high reset
//   sender_data      head word of the upstream FIFO (DATA_WIDTH)
//   sender_empty_n   upstream FIFO holds at least one word
//   sender_deq       dequeue strobe to the upstream FIFO
//   receiver_data    wide word, lane i at [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH]
//   receiver_mask    lane-valid mask for receiver_data
//   receiver_full_n  downstream FIFO can accept a word
//   receiver_enq     enqueue strobe to the downstream FIFO
//   flush            level request to send the current partial word
//   flush_ack        one-cycle pulse when a flush is done or dropped (empty)
//   busy             a partial word or a pending output word is held
module aggregator #(
  parameter int DATA_WIDTH  = 11,
  parameter int FETCH_WIDTH = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [DATA_WIDTH-1:0]             sender_data,
  input  logic                              sender_empty_n,
  output logic                              sender_deq,
  output logic [FETCH_WIDTH*DATA_WIDTH-1:0] receiver_data,
  output logic [FETCH_WIDTH-1:0]            receiver_mask,
  input  logic                              receiver_full_n,
  output logic                              receiver_enq,
  input  logic                              flush,
  output logic                              flush_ack,
  output logic                              busy
);

  localparam int CW = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_LANE = CW'(FETCH_WIDTH - 1);

  logic [DATA_WIDTH-1:0]             r_lanes [FETCH_WIDTH];
  logic [CW-1:0]                     r_count;
  logic [FETCH_WIDTH*DATA_WIDTH-1:0] r_out_data;
  logic [FETCH_WIDTH-1:0]            r_out_mask;
  logic                              r_out_valid;

  logic                              w_slot_free;
  logic                              w_last;
  logic                              w_deq;
  logic [CW:0]                       w_eff;
  logic                              w_full;
  logic                              w_flush_fire;
  logic                              w_load;
  logic [DATA_WIDTH-1:0]             w_lanes_in [FETCH_WIDTH];
  logic [FETCH_WIDTH*DATA_WIDTH-1:0] w_packed;
  logic [FETCH_WIDTH-1:0]            w_mask;

  // The output register is free if it is empty or is being drained right now.
  assign w_slot_free = !r_out_valid || receiver_full_n;
  assign w_last      = (r_count == LAST_LANE);

  // Filling the last lane needs the output register; other lanes never stall.
  assign w_deq = sender_empty_n && !rst && (!w_last || w_slot_free);

  // Lanes held after this cycle, counting a word accepted in this cycle.
  assign w_eff  = {1'b0, r_count} + (CW + 1)'(w_deq);
  assign w_full = w_deq && w_last;

  // eff can only reach FETCH_WIDTH through the full path, so !w_full means eff<FW.
  assign w_flush_fire = flush && (w_eff != '0) && !w_full && w_slot_free;
  assign w_load       = w_full || w_flush_fire;

  // Lanes above the fill point are always zero (cleared on load and reset),
  // so the merged view already has zeros in the unused lanes of a partial word.
  genvar gi;
  generate
    for (gi = 0; gi < FETCH_WIDTH; gi++) begin : g_lane
      assign w_lanes_in[gi] = (w_deq && (r_count == CW'(gi))) ? sender_data : r_lanes[gi];
      assign w_packed[gi*DATA_WIDTH +: DATA_WIDTH] = w_lanes_in[gi];
      assign w_mask[gi] = ((CW + 1)'(gi) < w_eff);

      always_ff @(posedge clk) begin
        if (rst || w_load) begin
          r_lanes[gi] <= '0;
        end else begin
          r_lanes[gi] <= w_lanes_in[gi];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (w_load) begin
      r_count <= '0;
    end else if (w_deq) begin
      r_count <= r_count + CW'(1);
    end
  end

  // Data and mask hold after the word drains; only valid drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_mask  <= '0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_packed;
      r_out_mask  <= w_mask;
    end else if (receiver_enq) begin
      r_out_valid <= 1'b0;
    end
  end

  assign sender_deq    = w_deq;
  assign receiver_data = r_out_data;
  assign receiver_mask = r_out_mask;
  assign receiver_enq  = r_out_valid && receiver_full_n && !rst;
  // A flush with nothing held is acknowledged and dropped.
  assign flush_ack     = !rst && flush && (w_load || (w_eff == '0));
  assign busy          = (r_count != '0) || r_out_valid;

endmodule

// File: tb/tb_aggregator.sv
module tb_aggregator;
  localparam int DW = 11;
  localparam int FW = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [DW-1:0]     sender_data = '0;
  logic              sender_empty_n = 1'b0;
  logic              sender_deq;
  logic [FW*DW-1:0]  receiver_data;
  logic [FW-1:0]     receiver_mask;
  logic              receiver_full_n = 1'b1;
  logic              receiver_enq;
  logic              flush = 1'b0;
  logic              flush_ack;
  logic              busy;

  aggregator #(.DATA_WIDTH(DW), .FETCH_WIDTH(FW)) dut (
    .clk(clk), .rst(rst),
    .sender_data(sender_data), .sender_empty_n(sender_empty_n), .sender_deq(sender_deq),
    .receiver_data(receiver_data), .receiver_mask(receiver_mask),
    .receiver_full_n(receiver_full_n), .receiver_enq(receiver_enq),
    .flush(flush), .flush_ack(flush_ack), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Upstream FIFO contents, popped when the DUT dequeues.
  int src[$];
  bit pop_pending = 1'b0;

  // Behavioural model: words held in the assembly and the pending output word.
  int          pend[$];
  bit          m_ov = 1'b0;
  int          m_out[FW];
  logic [FW-1:0] m_mask = '0;

  // Every DUT enqueue as {mask, data}, and the valid words it delivered.
  logic [63:0] log_q[$];
  int          dut_words[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] pk(input int a0, input int a1, input int a2, input int a3,
                                     input logic [3:0] m);
    logic [63:0] r;
    r = '0;
    r[10:0]  = 11'(a0);
    r[21:11] = 11'(a1);
    r[32:22] = 11'(a2);
    r[43:33] = 11'(a3);
    r[47:44] = m;
    return r;
  endfunction

  // Per-cycle compare and model update, away from the active edge.
  always @(negedge clk) begin : monitor
    bit          sf, e_enq, e_deq, full, fire, e_ack, e_busy;
    int          eff;
    logic [63:0] e_data;
    sf     = !m_ov || receiver_full_n;
    e_enq  = m_ov && receiver_full_n && !rst;
    e_deq  = sender_empty_n && !rst && (pend.size() != FW - 1 || sf);
    eff    = pend.size() + int'(e_deq);
    full   = (eff == FW);
    fire   = flush && eff > 0 && eff < FW && sf;
    e_ack  = !rst && flush && (full || fire || eff == 0);
    e_busy = (pend.size() != 0) || m_ov;
    e_data = '0;
    for (int i = 0; i < FW; i++) e_data[i*DW +: DW] = DW'(m_out[i]);
    chk("sender_deq", 64'(sender_deq), 64'(e_deq));
    chk("receiver_enq", 64'(receiver_enq), 64'(e_enq));
    chk("flush_ack", 64'(flush_ack), 64'(e_ack));
    chk("busy", 64'(busy), 64'(e_busy));
    chk("receiver_data", 64'(receiver_data), e_data);
    chk("receiver_mask", 64'(receiver_mask), 64'(m_mask));

    if (receiver_enq && !rst) begin
      log_q.push_back({16'h0, receiver_mask, receiver_data});
      for (int i = 0; i < FW; i++)
        if (receiver_mask[i]) dut_words.push_back(int'(receiver_data[i*DW +: DW]));
    end
    pop_pending = sender_deq;

    if (rst) begin
      pend.delete();
      m_ov   = 1'b0;
      m_mask = '0;
      for (int i = 0; i < FW; i++) m_out[i] = 0;
    end else begin
      if (e_deq) pend.push_back(int'(sender_data));
      if (full || fire) begin
        for (int i = 0; i < FW; i++) begin
          m_out[i]  = (i < pend.size()) ? pend[i] : 0;
          m_mask[i] = (i < pend.size());
        end
        pend.delete();
        m_ov = 1'b1;
      end else if (e_enq) begin
        m_ov = 1'b0;
      end
    end
  end

  // One clock of stimulus: pop a consumed word, then drive the next inputs.
  task automatic cyc(input logic r, input logic fn, input logic fl, input logic g);
    @(posedge clk);
    #1;
    if (pop_pending && src.size() > 0) void'(src.pop_front());
    rst             = r;
    receiver_full_n = fn;
    flush           = fl;
    sender_empty_n  = g && (src.size() > 0);
    sender_data     = (src.size() > 0) ? DW'(src[0]) : '0;
  endtask

  initial begin : stim
    int base;
    int cycles;
    m_out = '{default: 0};

    // Reset state
    cyc(1, 1, 0, 0);
    cyc(1, 1, 0, 0);
    cyc(0, 1, 0, 0);
    #1;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_mask", 64'(receiver_mask), 64'd0);
    chk("reset_enq", 64'(receiver_enq), 64'd0);

    // Streaming 0..15 without backpressure
    base = log_q.size();
    for (int v = 0; v < 16; v++) src.push_back(v);
    for (int i = 0; i < 22; i++) cyc(0, 1, 0, 1);
    chk("stream_count", 64'(log_q.size() - base), 64'd4);
    if (log_q.size() >= base + 4) begin
      chk("stream_w0", log_q[base],     pk(0, 1, 2, 3, 4'b1111));
      chk("stream_w1", log_q[base + 1], pk(4, 5, 6, 7, 4'b1111));
      chk("stream_w3", log_q[base + 3], pk(12, 13, 14, 15, 4'b1111));
    end

    // Flush of a partial word 5,6,7 with no more input
    base = log_q.size();
    src.push_back(5); src.push_back(6); src.push_back(7);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 1);
    cyc(0, 1, 1, 1);
    #1;
    chk("flush_ack_partial", 64'(flush_ack), 64'd1);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 1);
    chk("flush_partial_word", (log_q.size() > base) ? log_q[base] : 64'hDEAD, pk(5, 6, 7, 0, 4'b0111));
    #1;
    chk("flush_partial_busy", 64'(busy), 64'd0);

    // Flush in the same cycle word 9 lands in lane 2
    base = log_q.size();
    src.push_back(3); src.push_back(4); src.push_back(9);
    cyc(0, 1, 0, 1);
    cyc(0, 1, 0, 1);
    cyc(0, 1, 1, 1);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 1);
    chk("flush_coincident", (log_q.size() > base) ? log_q[base] : 64'hDEAD, pk(3, 4, 9, 0, 4'b0111));

    // Flush with three lanes held plus an accept gives a full word
    base = log_q.size();
    src.push_back(11); src.push_back(12); src.push_back(13); src.push_back(14);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 1);
    cyc(0, 1, 1, 1);
    #1;
    chk("flush_full_ack", 64'(flush_ack), 64'd1);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 1);
    chk("flush_full_word", (log_q.size() > base) ? log_q[base] : 64'hDEAD, pk(11, 12, 13, 14, 4'b1111));

    // Stall at full: pending word blocked, three more lanes fill, then stall
    base = log_q.size();
    for (int v = 30; v < 38; v++) src.push_back(v);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 1);
    #1;
    chk("stall_deq", 64'(sender_deq), 64'd0);
    chk("stall_data", 64'(receiver_data), pk(30, 31, 32, 33, 4'b0000));
    cyc(0, 1, 0, 1);
    #1;
    chk("release_enq", 64'(receiver_enq), 64'd1);
    chk("release_deq", 64'(sender_deq), 64'd1);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 1);
    chk("stall_count", 64'(log_q.size() - base), 64'd2);
    if (log_q.size() >= base + 2) begin
      chk("stall_w0", log_q[base],     pk(30, 31, 32, 33, 4'b1111));
      chk("stall_w1", log_q[base + 1], pk(34, 35, 36, 37, 4'b1111));
    end

    // Reset with a pending word and two lanes held
    for (int v = 40; v < 46; v++) src.push_back(v);
    for (int i = 0; i < 9; i++) cyc(0, 0, 0, 1);
    cyc(1, 0, 0, 1);
    cyc(0, 1, 0, 1);
    #1;
    chk("post_reset_enq", 64'(receiver_enq), 64'd0);
    chk("post_reset_busy", 64'(busy), 64'd0);
    chk("post_reset_mask", 64'(receiver_mask), 64'd0);
    base = log_q.size();
    for (int v = 20; v < 24; v++) src.push_back(v);
    for (int i = 0; i < 8; i++) cyc(0, 1, 0, 1);
    chk("post_reset_count", 64'(log_q.size() - base), 64'd1);
    chk("post_reset_word", (log_q.size() > base) ? log_q[base] : 64'hDEAD, pk(20, 21, 22, 23, 4'b1111));

    // Random backpressure on both sides, 200 words
    dut_words.delete();
    for (int i = 0; i < 200; i++) src.push_back((i * 37 + 100) & 11'h7FF);
    cycles = 0;
    while (dut_words.size() < 200 && cycles < 4000) begin
      cyc(0, 1'($urandom_range(0, 1)), 0, 1'($urandom_range(0, 1)));
      cycles++;
    end
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 1);
    chk("random_word_count", 64'(dut_words.size()), 64'd200);
    for (int i = 0; i < 200 && i < dut_words.size(); i++)
      chk("random_word", 64'(dut_words[i]), 64'((i * 37 + 100) & 11'h7FF));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/aggregator.md
Name: aggregator

Overview:
- Packs a stream of narrow DATA_WIDTH words into FETCH_WIDTH-lane wide words. It is the inverse of the deaggregator stage.
- Dequeues from a narrow upstream FIFO and enqueues into a wide downstream FIFO using the same empty_n/deq and full_n/enq handshake convention.
- A flush request emits a partially filled word, with a lane-valid mask, at the end of a stream.

Parameters:
- DATA_WIDTH, 11, width of one narrow word (one lane).
- FETCH_WIDTH, 4, lanes per wide word; must be ≥2.

Ports:
- clk  input  1  single clock for the block.
- rst  input  1  synchronous, active-high reset.
- sender_data  input  DATA_WIDTH  head word of the upstream FIFO; valid when sender_empty_n=1.
- sender_empty_n  input  1  upstream FIFO is non-empty.
- sender_deq  output  1  dequeue strobe to upstream; sender_data is consumed in this cycle.
- receiver_data  output  FETCH_WIDTH*DATA_WIDTH  wide word; lane i occupies bits [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH].
- receiver_mask  output  FETCH_WIDTH  lane-valid mask accompanying receiver_data.
- receiver_full_n  input  1  downstream FIFO can accept a word.
- receiver_enq  output  1  enqueue strobe to downstream.
- flush  input  1  level request to emit the current partial word.
- flush_ack  output  1  one-cycle pulse when a flush is performed, or dropped because the block is empty.
- busy  output  1  high when count≠0 or out_valid=1.

Behaviour:
- State
  - Assembly register: FETCH_WIDTH lanes.
  - count: 0..FETCH_WIDTH-1, the next lane to fill.
  - Output register: out_data, out_mask, out_valid.
- Reset (rst=1 at posedge)
  - count=0, assembly lanes=0, out_valid=0, out_data=0, out_mask=0.
  - While rst=1, sender_deq=0, receiver_enq=0, flush_ack=0.
  - Reset mid-stream discards any partial or pending word without emitting it.
- Combinational outputs
  - receiver_enq = out_valid & receiver_full_n.
  - receiver_data = out_data; receiver_mask = out_mask.
- slot_free = !out_valid | receiver_full_n. The output register is empty or drains this cycle.
- Dequeue rule
  - sender_deq = sender_empty_n & !rst & (count≠FETCH_WIDTH-1 | slot_free).
  - The block never consumes a word it cannot store.
- Accepting a word (sender_deq=1)
  - The word is written to lane[count].
  - If count=FETCH_WIDTH-1: the assembled word (lanes 0..FETCH_WIDTH-2 plus the new word) loads into the output register with mask all-ones. out_valid=1, count←0, assembly cleared.
  - Otherwise count←count+1.
- Flush
  - Let eff = count + sender_deq, the lanes held including this cycle's accept.
  - A flush fires in a cycle when flush=1, 0<eff<FETCH_WIDTH, and slot_free.
  - When it fires, the output register loads the assembly contents including any word accepted this cycle. Unused lanes are 0; out_mask = low eff bits set. count←0, assembly cleared, flush_ack=1.
  - If eff=FETCH_WIDTH, the normal full-word path applies and satisfies the flush; flush_ack=1.
  - If flush=1 with eff=0: flush_ack=1 with no output, since there is nothing to flush.
  - If flush=1 but slot_free=0 with a partial word: the flush waits, flush_ack=0. Further sender words may still be accepted into free lanes.
- Latency and throughput
  - Latency: the last lane dequeued (or the flush) at cycle N gives out_valid at N+1. receiver_enq is asserted at N+1 if receiver_full_n=1.
  - Sustained throughput: 1 narrow word per cycle with no bubbles when the downstream never stalls.
- Backpressure: while out_valid=1 and receiver_full_n=0, out_data and out_mask hold stable. Lanes 0..FETCH_WIDTH-2 can still fill; dequeue then stalls at count=FETCH_WIDTH-1.
- Lane order: the first narrow word received goes to lane 0. A deaggregator fed by this block reproduces the original order.

Test Plan:
- Streaming: FW=4, DW=11. Upstream supplies 0,1,2,… continuously; receiver_full_n=1.
  - Expect wide words {3,2,1,0}, {7,6,5,4}, … with mask 4'b1111.
  - First receiver_enq one cycle after the 4th sender_deq; then one enq every 4 cycles.
- Random backpressure: receiver_full_n random 50%, sender_empty_n random 50%, 200 words.
  - Scoreboard: concatenated lanes equal the input sequence with no loss or duplication.
  - receiver_data is stable while out_valid=1 and receiver_full_n=0.
- Flush partial: send 5,6,7, then assert flush with no further sender data.
  - Expect one enq with lanes {0,7,6,5}, mask 4'b0111, flush_ack pulse; busy→0.
- Flush coincident with accept: count=2, flush=1 in the same cycle that word 9 is dequeued.
  - Expect mask 4'b0111 with lane2=9.
  - Separately, flush with count=3 plus an accept gives a full word with mask 4'b1111 and flush_ack=1.
- Stall at full: receiver_full_n=0 with out_valid=1. Feed 4 more words.
  - Expect 3 accepted (count=3), then sender_deq=0.
  - Release receiver_full_n: the old word enqueues and the 4th word is accepted in the same cycle.
- Reset mid-operation: rst=1 for 1 cycle with count=2 and out_valid=1.
  - Next cycle: receiver_enq=0, busy=0, mask 0.
  - Subsequent input 20,21,22,23 gives the word {23,22,21,20} only.
